// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// i2c_target: I2C target endpoint. Oversamples SCL/SDA on clk, filters glitches,
// detects START/STOP, matches TARGET_ADDR, ACKs, receives write bytes into
// rx_data and serves read bytes from tx_data. SDA is open-drain (0 or z only).
module i2c_target #(
    parameter logic [6:0]  TARGET_ADDR = 7'h50,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    localparam int unsigned      CW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0]    CNT_MAX = CW'(FILTER_LEN - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_WR_DATA  = 3'd3;
    localparam logic [2:0] ST_WR_ACK   = 3'd4;
    localparam logic [2:0] ST_RD_DATA  = 3'd5;
    localparam logic [2:0] ST_RD_ACK   = 3'd6;

    // Index 1 carries SCL, index 0 carries SDA through the input path.
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    filt;
    logic [1:0]    filt_q;
    logic [CW-1:0] run_cnt [2];

    logic scl_f, scl_p, sda_f, sda_p;
    logic scl_rise, scl_fall, start_c, stop_c;

    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic       byte_done;
    logic [7:0] shreg;
    logic [6:0] txsr;
    logic       rw;
    logic       ack_in;
    logic       sda_oe;

    // Open-drain output; sda_oe clears asynchronously on reset, releasing the bus at once.
    assign sda = sda_oe ? 1'b0 : 1'bz;

    // Two-stage synchronizer and run-length filter: a new level is accepted only
    // after FILTER_LEN consecutive identical synchronized samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= '1;
            sync2  <= '1;
            filt   <= '1;
            filt_q <= '1;
            for (int unsigned i = 0; i < 2; i++) begin
                run_cnt[i] <= '0;
            end
        end else begin
            sync1  <= {scl, sda};
            sync2  <= sync1;
            filt_q <= filt;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    run_cnt[i] <= '0;
                end else if (run_cnt[i] == CNT_MAX) begin
                    filt[i]    <= sync2[i];
                    run_cnt[i] <= '0;
                end else begin
                    run_cnt[i] <= run_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Edge and bus-condition detection on the filtered levels only.
    always_comb begin
        scl_f    = filt[1];
        scl_p    = filt_q[1];
        sda_f    = filt[0];
        sda_p    = filt_q[0];
        scl_rise = scl_f & ~scl_p;
        scl_fall = ~scl_f & scl_p;
        start_c  = scl_f & scl_p & sda_p & ~sda_f;
        stop_c   = scl_f & scl_p & ~sda_p & sda_f;
    end

    // Protocol FSM: bits sampled on SCL rise, SDA drive changed on SCL fall;
    // STOP/START override whatever the current state would do on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            shreg     <= '0;
            txsr      <= '0;
            rw        <= 1'b0;
            ack_in    <= 1'b1;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            if (stop_c) begin
                state     <= ST_IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                byte_done <= 1'b0;
                bit_cnt   <= '0;
            end else if (start_c) begin
                state     <= ST_ADDR;
                sda_oe    <= 1'b0;
                byte_done <= 1'b0;
                bit_cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        sda_oe <= 1'b0;
                    end
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_f};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_done <= 1'b1;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            if (shreg[7:1] == TARGET_ADDR) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rw     <= shreg[0];
                                state  <= ST_ADDR_ACK;
                            end else begin
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (!rw) begin
                                sda_oe <= 1'b0;
                                state  <= ST_WR_DATA;
                            end else begin
                                tx_req <= 1'b1;
                                txsr   <= tx_data[6:0];
                                sda_oe <= ~tx_data[7];
                                state  <= ST_RD_DATA;
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_f};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data   <= {shreg[6:0], sda_f};
                                rx_valid  <= 1'b1;
                                byte_done <= 1'b1;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            sda_oe    <= 1'b1;
                            state     <= ST_WR_ACK;
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= ST_WR_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        // bit_cnt counts bits already placed on the bus, minus one.
                        if (scl_fall) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                sda_oe <= 1'b0;
                                state  <= ST_RD_ACK;
                            end else begin
                                sda_oe <= ~txsr[6];
                                txsr   <= {txsr[5:0], 1'b0};
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            ack_in <= sda_f;
                        end else if (scl_fall) begin
                            bit_cnt <= '0;
                            if (!ack_in) begin
                                tx_req <= 1'b1;
                                txsr   <= tx_data[6:0];
                                sda_oe <= ~tx_data[7];
                                state  <= ST_RD_DATA;
                            end else begin
                                sda_oe <= 1'b0;
                                busy   <= 1'b0;
                                state  <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                        state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
